// File: rtl/cu_edge_data_accumulate_pkg.sv
// Shared types, constants and helpers for the CU edge-data accumulate stage.
package cu_edge_data_accumulate_pkg;

  localparam int unsigned DATA_SIZE        = 4;
  localparam int unsigned CACHELINE_SIZE   = 128;
  localparam logic [63:0] ADDRESS_MOD_MASK = 64'(CACHELINE_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    VERTEX_REQ,
    VERTEX_WAIT,
    ACCUM,
    WRITE_OUT
  } accum_state;

  typedef enum logic [1:0] {
    NO_COMMAND,
    READ_CL_NA,
    WRITE_NA
  } command_e;

  typedef enum logic [1:0] {
    CMD_INVALID,
    CMD_READ,
    CMD_WRITE
  } cmd_type_e;

  typedef enum logic [1:0] {
    STRUCT_INVALID,
    READ_GRAPH_DATA,
    WRITE_GRAPH_DATA
  } vertex_struct_e;

  typedef struct packed {
    logic        valid;
    logic [63:0] auxiliary2;
  } WEDInterface;

  typedef struct packed {
    logic alfull;
    logic empty;
  } BufferStatus;

  typedef struct packed {
    logic        valid;
    logic [31:0] id;
    logic [31:0] in_degree;
  } VertexInterface;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } EdgeData;

  typedef struct packed {
    logic           valid;
    command_e       command;
    cmd_type_e      cmd_type;
    vertex_struct_e vertex_struct;
    logic [11:0]    size;
    logic [63:0]    address;
    logic [4:0]     cacheline_offest;
    logic [7:0]     cu_id;
  } CommandBufferLine;

  typedef struct packed {
    logic             valid;
    CommandBufferLine cmd;
    logic [511:0]     data;
  } ReadWriteDataLine;

  function automatic logic [31:0] swap_endianess_word_hf(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

  // Builds a full 128-byte cacheline holding one byte-swapped word at a word offset.
  function automatic logic [1023:0] write_data_place_cacheline_hf(input logic [4:0]  offset,
                                                                  input logic [31:0] word);
    logic [1023:0] line;
    line = '0;
    line[{offset, 5'b00000} +: 32] = swap_endianess_word_hf(word);
    return line;
  endfunction

endpackage

// File: rtl/cu_edge_data_accumulate_if.sv
// Bus bundle between the accumulate stage, its source FIFOs and the write arbiter.
interface cu_edge_data_accumulate_if;
  import cu_edge_data_accumulate_pkg::*;

  logic             enabled_in;
  WEDInterface      wed_request_in;
  BufferStatus      vertex_buffer_status;
  VertexInterface   vertex_job;
  logic             vertex_request;
  BufferStatus      data_buffer_status;
  EdgeData          edge_data;
  logic             edge_data_request;
  BufferStatus      write_buffer_status;
  CommandBufferLine write_command_out;
  ReadWriteDataLine write_data_0_out;
  ReadWriteDataLine write_data_1_out;
  logic [31:0]      vertex_done_count;

  modport master (
    output enabled_in, wed_request_in, vertex_buffer_status, vertex_job,
           data_buffer_status, edge_data, write_buffer_status,
    input  vertex_request, edge_data_request, write_command_out,
           write_data_0_out, write_data_1_out, vertex_done_count
  );

  modport slave (
    input  enabled_in, wed_request_in, vertex_buffer_status, vertex_job,
           data_buffer_status, edge_data, write_buffer_status,
    output vertex_request, edge_data_request, write_command_out,
           write_data_0_out, write_data_1_out, vertex_done_count
  );
endinterface

// File: rtl/cu_edge_data_accumulate.sv
// Pops in_degree edge words per vertex job, sums them and writes the sum
// to the vertex slot of the output array as one cacheline-positioned command.
module cu_edge_data_accumulate
  import cu_edge_data_accumulate_pkg::*;
#(
  parameter int unsigned CU_ID = 1
) (
  input logic                      clock,
  input logic                      rstn,
  cu_edge_data_accumulate_if.slave bus
);

  accum_state       state_q, state_d;
  logic             enabled_q;
  logic [63:0]      aux2_q, aux2_d;
  logic [31:0]      id_q, id_d;
  logic [31:0]      in_degree_q, in_degree_d;
  logic [31:0]      sum_q, sum_d;
  logic [31:0]      req_cnt_q, req_cnt_d;
  logic [31:0]      rcv_cnt_q, rcv_cnt_d;
  logic             job_seen_q, job_seen_d;
  logic             vertex_request_q, vertex_request_d;
  logic             edge_request_q, edge_request_d;
  CommandBufferLine cmd_q, cmd_d;
  ReadWriteDataLine data0_q, data0_d;
  ReadWriteDataLine data1_q, data1_d;
  logic [31:0]      done_q, done_d;

  logic [63:0]      slot_byte;
  logic [4:0]       offset;
  logic [1023:0]    line;

  assign slot_byte = {32'b0, id_q} << 2;
  assign offset    = 5'((slot_byte & ADDRESS_MOD_MASK) >> 2);
  assign line      = write_data_place_cacheline_hf(offset, sum_q);

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d          = state_q;
    aux2_d           = aux2_q;
    id_d             = id_q;
    in_degree_d      = in_degree_q;
    sum_d            = sum_q;
    req_cnt_d        = req_cnt_q;
    rcv_cnt_d        = rcv_cnt_q;
    job_seen_d       = job_seen_q;
    vertex_request_d = 1'b0;
    edge_request_d   = 1'b0;
    cmd_d            = '0;
    data0_d          = '0;
    data1_d          = '0;
    done_d           = done_q;

    if (bus.wed_request_in.valid) begin
      aux2_d = bus.wed_request_in.auxiliary2;
    end

    // Responses to pops already issued are captured even while frozen;
    // only new pops and state moves wait for enable.
    if (state_q == VERTEX_WAIT && bus.vertex_job.valid) begin
      id_d        = bus.vertex_job.id;
      in_degree_d = bus.vertex_job.in_degree;
      job_seen_d  = 1'b1;
    end
    if (state_q == ACCUM && bus.edge_data.valid) begin
      sum_d     = sum_q + bus.edge_data.data;
      rcv_cnt_d = rcv_cnt_q + 32'd1;
    end

    if (enabled_q) begin
      case (state_q)
        IDLE: begin
          if (bus.wed_request_in.valid && !bus.vertex_buffer_status.empty) begin
            state_d = VERTEX_REQ;
          end
        end
        VERTEX_REQ: begin
          vertex_request_d = 1'b1;
          state_d          = VERTEX_WAIT;
        end
        VERTEX_WAIT: begin
          if (job_seen_d) begin
            job_seen_d = 1'b0;
            sum_d      = '0;
            req_cnt_d  = '0;
            rcv_cnt_d  = '0;
            state_d    = (in_degree_d == '0) ? WRITE_OUT : ACCUM;
          end
        end
        ACCUM: begin
          edge_request_d = !bus.data_buffer_status.empty && (req_cnt_q != in_degree_q);
          if (edge_request_d) begin
            req_cnt_d = req_cnt_q + 32'd1;
          end
          if (rcv_cnt_d == in_degree_q) begin
            state_d = WRITE_OUT;
          end
        end
        WRITE_OUT: begin
          if (!bus.write_buffer_status.alfull) begin
            cmd_d.valid            = 1'b1;
            cmd_d.command          = WRITE_NA;
            cmd_d.cmd_type         = CMD_WRITE;
            cmd_d.vertex_struct    = WRITE_GRAPH_DATA;
            cmd_d.size             = 12'(DATA_SIZE);
            cmd_d.address          = aux2_q + slot_byte;
            cmd_d.cacheline_offest = offset;
            cmd_d.cu_id            = 8'(CU_ID);
            data0_d.valid          = ~offset[4];
            data0_d.cmd            = cmd_d;
            data0_d.data           = line[511:0];
            data1_d.valid          = offset[4];
            data1_d.cmd            = cmd_d;
            data1_d.data           = line[1023:512];
            done_d                 = done_q + 32'd1;
            state_d                = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      state_q          <= IDLE;
      enabled_q        <= 1'b0;
      aux2_q           <= '0;
      id_q             <= '0;
      in_degree_q      <= '0;
      sum_q            <= '0;
      req_cnt_q        <= '0;
      rcv_cnt_q        <= '0;
      job_seen_q       <= 1'b0;
      vertex_request_q <= 1'b0;
      edge_request_q   <= 1'b0;
      cmd_q            <= '0;
      data0_q          <= '0;
      data1_q          <= '0;
      done_q           <= '0;
    end else begin
      state_q          <= state_d;
      enabled_q        <= bus.enabled_in;
      aux2_q           <= aux2_d;
      id_q             <= id_d;
      in_degree_q      <= in_degree_d;
      sum_q            <= sum_d;
      req_cnt_q        <= req_cnt_d;
      rcv_cnt_q        <= rcv_cnt_d;
      job_seen_q       <= job_seen_d;
      vertex_request_q <= vertex_request_d;
      edge_request_q   <= edge_request_d;
      cmd_q            <= cmd_d;
      data0_q          <= data0_d;
      data1_q          <= data1_d;
      done_q           <= done_d;
    end
  end

  assign bus.vertex_request    = vertex_request_q;
  assign bus.edge_data_request = edge_request_q;
  assign bus.write_command_out = cmd_q;
  assign bus.write_data_0_out  = data0_q;
  assign bus.write_data_1_out  = data1_q;
  assign bus.vertex_done_count = done_q;

endmodule

// File: tb/tb_cu_edge_data_accumulate.sv
// Scoreboard bench for cu_edge_data_accumulate: FIFO models feed the DUT,
// expected writes are queued at issue time and checked by a write monitor.
module tb_cu_edge_data_accumulate;
  import cu_edge_data_accumulate_pkg::*;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] deg;
  } vjob_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [4:0]  off;
    logic [31:0] sum;
    logic [31:0] done;
  } exp_t;

  typedef logic [31:0] words_t [8];

  logic clock = 1'b0;
  logic rstn  = 1'b0;

  cu_edge_data_accumulate_if bus ();

  cu_edge_data_accumulate #(.CU_ID(1)) dut (
    .clock (clock),
    .rstn  (rstn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pops = 0;
  int          delivered = 0;
  int          wr_count = 0;
  int          last_wr_cyc = 0;
  logic        stall = 1'b0;
  logic [31:0] exp_done = 0;
  vjob_t       vq[$];
  logic [31:0] eq[$];
  exp_t        sb[$];

  task automatic check(input string name, input logic [767:0] act, input logic [767:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Vertex FIFO model: a pop seen in cycle t returns the job in cycle t+1.
  initial begin
    logic  pop_v;
    vjob_t vj;
    vj = '0;
    bus.vertex_job = '0;
    bus.vertex_buffer_status = '0;
    bus.vertex_buffer_status.empty = 1'b1;
    forever begin
      @(negedge clock);
      pop_v = rstn && bus.vertex_request && (vq.size() > 0);
      if (pop_v) vj = vq.pop_front();
      bus.vertex_buffer_status.empty = (vq.size() == 0);
      @(posedge clock);
      #1;
      bus.vertex_job.valid     = pop_v;
      bus.vertex_job.id        = pop_v ? vj.id : '0;
      bus.vertex_job.in_degree = pop_v ? vj.deg : '0;
    end
  end

  // Edge-data FIFO model with an externally forced empty (stall).
  initial begin
    logic        pop_e;
    logic [31:0] w;
    w = '0;
    bus.edge_data = '0;
    bus.data_buffer_status = '0;
    bus.data_buffer_status.empty = 1'b1;
    forever begin
      @(negedge clock);
      pop_e = rstn && bus.edge_data_request;
      if (pop_e) begin
        pops++;
        if (eq.size() > 0) w = eq.pop_front();
        else pop_e = 1'b0;
      end
      bus.data_buffer_status.empty = (eq.size() == 0) || stall;
      @(posedge clock);
      #1;
      bus.edge_data.valid = pop_e;
      bus.edge_data.data  = pop_e ? w : '0;
      if (pop_e) delivered++;
    end
  end

  // Write monitor: pops the scoreboard whenever a write command appears.
  initial forever begin
    exp_t             e;
    CommandBufferLine ec;
    ReadWriteDataLine e0, e1;
    logic [511:0]     wl;
    logic [31:0]      sw;
    @(negedge clock);
    if (bus.write_command_out.valid) begin
      wr_count++;
      last_wr_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_write", 768'(bus.write_command_out.address), 768'(0));
      end else begin
        e  = sb.pop_front();
        ec = '0;
        ec.valid            = 1'b1;
        ec.command          = WRITE_NA;
        ec.cmd_type         = CMD_WRITE;
        ec.vertex_struct    = WRITE_GRAPH_DATA;
        ec.size             = 12'd4;
        ec.address          = e.addr;
        ec.cacheline_offest = e.off;
        ec.cu_id            = 8'd1;
        sw = {e.sum[7:0], e.sum[15:8], e.sum[23:16], e.sum[31:24]};
        wl = '0;
        wl[31:0] = sw;
        wl = wl << (32 * int'(e.off[3:0]));
        e0 = '{valid: ~e.off[4], cmd: ec, data: e.off[4] ? 512'(0) : wl};
        e1 = '{valid: e.off[4],  cmd: ec, data: e.off[4] ? wl : 512'(0)};
        check("wr_address", 768'(bus.write_command_out.address), 768'(e.addr));
        check("wr_offset", 768'(bus.write_command_out.cacheline_offest), 768'(e.off));
        check("wr_command", 768'(bus.write_command_out), 768'(ec));
        check("wr_data0", 768'(bus.write_data_0_out), 768'(e0));
        check("wr_data1", 768'(bus.write_data_1_out), 768'(e1));
        check("done_count", 768'(bus.vertex_done_count), 768'(e.done));
      end
    end
  end

  task automatic issue(input logic [31:0] id, input logic [31:0] deg, input words_t d,
                       input logic [31:0] sum, input logic [63:0] addr, input logic [4:0] off);
    exp_done++;
    sb.push_back('{addr: addr, off: off, sum: sum, done: exp_done});
    for (int unsigned i = 0; i < deg; i++) eq.push_back(d[i]);
    vq.push_back('{id: id, deg: deg});
  endtask

  task automatic wait_write(input int start, input string name);
    int n;
    n = 0;
    while (wr_count == start && n < 300) begin
      @(posedge clock);
      n++;
    end
    @(negedge clock);
    check(name, 768'(wr_count), 768'(start + 1));
  endtask

  task automatic wait_delivered(input int target);
    int n;
    n = 0;
    while (delivered < target && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("delivered", 768'(delivered), 768'(target));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_vreq"}, 768'(bus.vertex_request), 768'(0));
    check({tag, "_ereq"}, 768'(bus.edge_data_request), 768'(0));
    check({tag, "_cmd"}, 768'(bus.write_command_out), 768'(0));
    check({tag, "_d0"}, 768'(bus.write_data_0_out), 768'(0));
    check({tag, "_d1"}, 768'(bus.write_data_1_out), 768'(0));
    check({tag, "_done"}, 768'(bus.vertex_done_count), 768'(0));
  endtask

  initial begin
    words_t d;
    int     s;
    int     p;
    int     dbase;
    int     dcyc;
    bus.enabled_in = 1'b1;
    bus.wed_request_in = '{valid: 1'b1, auxiliary2: 64'h1000};
    bus.write_buffer_status = '0;
    d = '{default: 32'h0};

    repeat (4) @(posedge clock);
    @(negedge clock);
    check_outputs_zero("reset");
    @(posedge clock);
    #1 rstn = 1'b1;

    // Basic sum
    d = '{32'd1, 32'd2, 32'd3, 0, 0, 0, 0, 0};
    s = wr_count;
    issue(32'd5, 32'd3, d, 32'd6, 64'h1014, 5'd5);
    wait_write(s, "basic_write");

    // Zero degree: no edge pops, sum 0 lands in the upper half
    p = pops;
    s = wr_count;
    issue(32'd16, 32'd0, d, 32'd0, 64'h1040, 5'd16);
    wait_write(s, "zero_write");
    check("zero_no_pops", 768'(pops), 768'(p));

    // Half boundary and cacheline wrap
    d = '{32'h000000A5, 0, 0, 0, 0, 0, 0, 0};
    s = wr_count;
    issue(32'd15, 32'd1, d, 32'h000000A5, 64'h103C, 5'd15);
    wait_write(s, "id15_write");
    d = '{32'h12345678, 0, 0, 0, 0, 0, 0, 0};
    s = wr_count;
    issue(32'd31, 32'd1, d, 32'h12345678, 64'h107C, 5'd31);
    wait_write(s, "id31_write");
    d = '{32'h0000CAFE, 0, 0, 0, 0, 0, 0, 0};
    s = wr_count;
    issue(32'd32, 32'd1, d, 32'h0000CAFE, 64'h1080, 5'd0);
    wait_write(s, "id32_write");

    // Sum wraps modulo 2^32
    d = '{32'hFFFFFFFF, 32'h2, 0, 0, 0, 0, 0, 0};
    s = wr_count;
    issue(32'd7, 32'd2, d, 32'h1, 64'h101C, 5'd7);
    wait_write(s, "wrap_write");

    // Edge FIFO empty for 5 cycles mid-vertex
    d = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 0, 0};
    p = pops;
    s = wr_count;
    dbase = delivered;
    issue(32'd3, 32'd6, d, 32'd210, 64'h100C, 5'd3);
    wait_delivered(dbase + 2);
    @(posedge clock);
    #1 stall = 1'b1;
    repeat (5) @(posedge clock);
    #1 stall = 1'b0;
    wait_write(s, "stall_write");
    check("stall_pops", 768'(pops - p), 768'(6));

    // Write FIFO almost-full holds the write for 4 cycles
    bus.write_buffer_status.alfull = 1'b1;
    d = '{32'h00000099, 0, 0, 0, 0, 0, 0, 0};
    s = wr_count;
    dbase = delivered;
    issue(32'd9, 32'd1, d, 32'h99, 64'h1024, 5'd9);
    wait_delivered(dbase + 1);
    repeat (4) @(posedge clock);
    #1;
    check("alfull_hold", 768'(wr_count - s), 768'(0));
    bus.write_buffer_status.alfull = 1'b0;
    dcyc = cyc;
    wait_write(s, "alfull_write");
    check("alfull_release_cycle", 768'(last_wr_cyc), 768'(dcyc + 1));
    repeat (5) @(posedge clock);
    check("alfull_once", 768'(wr_count - s), 768'(1));

    // Reset after 2 of 4 words; partial sum is discarded
    dbase = delivered;
    eq.push_back(32'd100);
    eq.push_back(32'd200);
    vq.push_back('{id: 32'd20, deg: 32'd4});
    wait_delivered(dbase + 2);
    @(posedge clock);
    #1 rstn = 1'b0;
    @(posedge clock);
    #1 rstn = 1'b1;
    exp_done = 0;
    @(negedge clock);
    check_outputs_zero("midreset");

    d = '{32'd7, 32'd8, 0, 0, 0, 0, 0, 0};
    s = wr_count;
    issue(32'd21, 32'd2, d, 32'd15, 64'h1054, 5'd21);
    wait_write(s, "post_reset_write");

    repeat (5) @(posedge clock);
    check("sb_drained", 768'(sb.size()), 768'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1);
  end

endmodule
